// File: rtl/stream_rr_arbiter.sv
// N-way round-robin stream arbiter with a registered main/skid output stage.
// Optional packet locking (m_last/s_last) is enabled by defining ARB_PKT_LOCK_EN.
module stream_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       m_valid,
  output logic [N-1:0]       m_ready,
  input  logic [N*WIDTH-1:0] m_data,
`ifdef ARB_PKT_LOCK_EN
  input  logic [N-1:0]       m_last,
  output logic               s_last,
`endif
  output logic               s_valid,
  input  logic               s_ready,
  output logic [WIDTH-1:0]   s_data,
  output logic [IDW-1:0]     s_id
);

  logic [WIDTH-1:0] data_arr [N];
  logic [IDW-1:0]   ptr_reg;
  logic             skid_full_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic [IDW-1:0]   skid_id_reg;
  logic [N-1:0]     grant;
  logic [IDW-1:0]   gnt_id;
  logic             accept;
  logic [WIDTH-1:0] acc_data;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign data_arr[gi] = m_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef ARB_PKT_LOCK_EN
  logic           lock_reg;
  logic [IDW-1:0] lock_id_reg;
  logic           skid_last_reg;
  logic           acc_last;
`endif

  // Rotating priority: the search starts just after the last winner.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDW'((int'(ptr_reg) + off) % N);
      if (!found && m_valid[idx]) begin
        found       = 1'b1;
        gnt_id      = idx;
        grant[idx]  = 1'b1;
      end
    end
`ifdef ARB_PKT_LOCK_EN
    if (lock_reg) begin
      grant              = '0;
      gnt_id             = lock_id_reg;
      grant[lock_id_reg] = m_valid[lock_id_reg];
    end
`endif
  end

  assign m_ready  = (skid_full_reg || rst) ? '0 : grant;
  assign accept   = |(m_valid & m_ready);
  assign acc_data = data_arr[gnt_id];
`ifdef ARB_PKT_LOCK_EN
  assign acc_last = m_last[gnt_id];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= IDW'(N - 1);
      skid_full_reg <= 1'b0;
      skid_data_reg <= '0;
      skid_id_reg   <= '0;
      s_valid       <= 1'b0;
      s_data        <= '0;
      s_id          <= '0;
`ifdef ARB_PKT_LOCK_EN
      lock_reg      <= 1'b0;
      lock_id_reg   <= '0;
      skid_last_reg <= 1'b0;
      s_last        <= 1'b0;
`endif
    end else begin
      if (skid_full_reg) begin
        // m_ready is low here, so nothing new can arrive while the skid drains.
        if (s_ready) begin
          s_valid       <= 1'b1;
          s_data        <= skid_data_reg;
          s_id          <= skid_id_reg;
          skid_full_reg <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
          s_last        <= skid_last_reg;
`endif
        end
      end else if (accept) begin
        if (!s_valid || s_ready) begin
          s_valid <= 1'b1;
          s_data  <= acc_data;
          s_id    <= gnt_id;
`ifdef ARB_PKT_LOCK_EN
          s_last  <= acc_last;
`endif
        end else begin
          skid_full_reg <= 1'b1;
          skid_data_reg <= acc_data;
          skid_id_reg   <= gnt_id;
`ifdef ARB_PKT_LOCK_EN
          skid_last_reg <= acc_last;
`endif
        end
      end else if (s_ready) begin
        s_valid <= 1'b0;
      end

      if (accept) begin
`ifdef ARB_PKT_LOCK_EN
        if (acc_last) begin
          ptr_reg  <= gnt_id;
          lock_reg <= 1'b0;
        end else begin
          lock_reg    <= 1'b1;
          lock_id_reg <= gnt_id;
        end
`else
        ptr_reg <= gnt_id;
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: vector table, corner sequences,
// and a randomized run checked by an acceptance-order scoreboard.
module tb_stream_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       m_valid;
  logic [N-1:0]       m_ready;
  logic [N*WIDTH-1:0] m_data;
  logic               s_valid;
  logic               s_ready;
  logic [WIDTH-1:0]   s_data;
  logic [IDW-1:0]     s_id;
`ifdef ARB_PKT_LOCK_EN
  logic [N-1:0]       m_last;
  logic               s_last;
`endif

  int checks = 0;
  int errors = 0;

  stream_rr_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef ARB_PKT_LOCK_EN
    .m_last(m_last), .s_last(s_last),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_id(s_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: beats pushed on acceptance, popped when they leave on s_*.
  logic [IDW+WIDTH-1:0] sb_q [$];
  logic                 prev_stall = 1'b0;
  logic [WIDTH-1:0]     prev_data;
  logic [IDW-1:0]       prev_id;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("onehot_ready", {31'd0, $onehot0(m_ready)}, 32'd1);
      if (prev_stall) begin
        check("hold_valid", {31'd0, s_valid}, 32'd1);
        check("hold_data_id", {22'd0, s_id, s_data}, {22'd0, prev_id, prev_data});
      end
      if (s_valid && s_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", {22'd0, s_id, s_data}, 32'hFFFF_FFFF);
        end else begin
          check("sb_beat", {22'd0, s_id, s_data}, {22'd0, sb_q.pop_front()});
        end
      end
      for (int i = 0; i < N; i++)
        if (m_valid[i] && m_ready[i])
          sb_q.push_back({IDW'(i), m_data[i*WIDTH +: WIDTH]});
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      prev_id    = s_id;
    end
  end

  typedef struct {
    logic [N-1:0]   mv;
    logic           sr;
    logic [N-1:0]   exp_rdy;
    logic           exp_sv;
    logic [IDW-1:0] exp_id;
  } vec_t;
  vec_t vecs [16];

  task automatic drive(input logic [N-1:0] mv, input logic sr);
    @(posedge clk); #1;
    m_valid = mv;
    s_ready = sr;
    m_data  = 32'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; m_valid = '0; s_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] outs [8];
  int n_out;
  int idx;
  logic acc;

  initial begin
    rst = 1'b1; m_valid = '0; s_ready = 1'b0; m_data = '0;
`ifdef ARB_PKT_LOCK_EN
    m_last = '1;
`endif
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0};
    vecs[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};
    vecs[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0};
    vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0};
    vecs[11] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd1};
    vecs[12] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_ready", {28'd0, m_ready}, 32'd0);
    check("rst_s_valid", {31'd0, s_valid}, 32'd0);
    check("rst_s_data", {24'd0, s_data}, 32'd0);
    check("rst_s_id", {30'd0, s_id}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].mv, vecs[i].sr);
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_m_ready", i), {28'd0, m_ready}, {28'd0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_s_valid", i), {31'd0, s_valid}, {31'd0, vecs[i].exp_sv});
      if (vecs[i].exp_sv)
        check($sformatf("vec%0d_s_id", i), {30'd0, s_id}, {30'd0, vecs[i].exp_id});
      $display("vec %0d: m_valid=%b s_ready=%b m_ready=%b s_valid=%b s_id=%0d",
               i, vecs[i].mv, vecs[i].sr, m_ready, s_valid, s_id);
    end

    // Stream from requester 1 with a 3-cycle downstream stall mid-stream.
    do_reset();
    idx = 0; n_out = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive((idx < 4) ? 4'b0010 : 4'b0000, !(cyc >= 2 && cyc <= 4));
      m_data[WIDTH +: WIDTH] = 8'h10 + 8'(idx);
      @(negedge clk);
      if (cyc == 3) check("stall_skid_blocks_ready", {28'd0, m_ready}, 32'd0);
      if (s_valid && s_ready && n_out < 8) begin
        outs[n_out] = s_data;
        n_out++;
      end
      acc = m_valid[1] && m_ready[1];
      if (acc) idx++;
    end
    check("stall_out_count", n_out, 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("stall_out%0d", k), {24'd0, outs[k]}, 32'h10 + k);
    $display("stall stream: %0d beats emitted", n_out);

    // Reset while main and skid are both occupied.
    do_reset();
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    @(negedge clk);
    check("pre_rst_s_valid", {31'd0, s_valid}, 32'd1);
    check("pre_rst_skid_full_ready", {28'd0, m_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_m_ready", {28'd0, m_ready}, 32'd0);
    drive(4'b1111, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_valid", {31'd0, s_valid}, 32'd0);
    check("post_rst_first_grant", {28'd0, m_ready}, 32'd1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    check("post_rst_s_id", {30'd0, s_id}, 32'd0);
    check("post_rst_s_valid2", {31'd0, s_valid}, 32'd1);
    $display("reset mid-transfer: done");

`ifdef ARB_PKT_LOCK_EN
    // Requester 2 sends a 3-beat packet while requester 0 is also waiting.
    do_reset();
    idx = 0; n_out = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive({1'b0, idx < 3, 1'b0, cyc >= 1 && cyc < 4}, 1'b1);
      m_last = {2'b11, idx == 2, 1'b1};
      @(negedge clk);
      if (s_valid && s_ready && n_out < 8) begin
        outs[n_out] = {5'd0, s_last, s_id};
        n_out++;
      end
      if (m_valid[2] && m_ready[2]) idx++;
    end
    check("lock_count", n_out, 32'd4);
    check("lock_b0", {24'd0, outs[0]}, 32'h2);
    check("lock_b1", {24'd0, outs[1]}, 32'h2);
    check("lock_b2", {24'd0, outs[2]}, 32'h6);
    check("lock_b3", {24'd0, outs[3]}, 32'h4);
    m_last = '1;
    $display("packet lock: %0d beats emitted", n_out);
`endif

    // Random traffic; the scoreboard checks order and content.
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++)
      drive(4'($urandom_range(0, 15)), ($urandom % 4) != 0);
    for (int cyc = 0; cyc < 6; cyc++) drive(4'b0000, 1'b1);
    @(negedge clk);
    check("random_drain_empty", sb_q.size(), 32'd0);
    check("random_drain_s_valid", {31'd0, s_valid}, 32'd0);
    $display("random run: 10000 cycles complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
